pe_vec_pipe: RTL and testbench

//  LANES-wide, 2-stage pipelined PE vector: MAC / EWM / EWA per lane, plus an internal-accumulate mode (ACC).

---
 rtl/pe_vec_pipe.sv | 164 ++++++++++++++++
 tb/tb_pe_vec_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_pipe.sv
// pe_vec_pipe: LANES-wide, two-stage pipelined PE vector.
// Each lane does MAC (a*b + acc_in), EWM (a*b), EWA ((a+b) << FRAC_BITS) or
// ACC (a*b added into a per-lane internal accumulator). Results are either
// saturated or wrapped, with a per-lane overflow flag.
//
// Handshake: a beat moves on in_valid & in_ready, and a result moves on
// out_valid & out_ready. advance = !out_valid | out_ready. When advance is low,
// every stage holds, so result_out and out_ovf stay stable during a stall.
// in_ready comes combinationally from out_ready and is forced low in reset.
module pe_vec_pipe #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   mode,
    input  logic                         in_last,
    input  logic                         sat_en,
    input  logic [LANES*DATA_WIDTH-1:0]  a_in,
    input  logic [LANES*DATA_WIDTH-1:0]  b_in,
    input  logic [LANES*ACC_WIDTH-1:0]   acc_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   result_out,
    output logic [LANES-1:0]             out_ovf,
    output logic [CNT_WIDTH-1:0]         acc_cnt
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_MAC = 2'd0,
        MODE_EWM = 2'd1,
        MODE_EWA = 2'd2,
        MODE_ACC = 2'd3
    } mode_t;

    logic advance;

    // Stage-1 registers
    logic                        s1_valid;
    mode_t                       s1_mode;
    logic                        s1_last;
    logic                        s1_sat;
    logic signed [PW-1:0]        s1_prod [LANES];
    logic signed [ACC_WIDTH-1:0] s1_ewa  [LANES];
    logic signed [ACC_WIDTH-1:0] s1_acc  [LANES];

    // Per-lane combinational terms
    logic signed [PW-1:0]        prod_d   [LANES];
    logic signed [ACC_WIDTH-1:0] ewa_d    [LANES];
    logic signed [ACC_WIDTH-1:0] lane_res [LANES];
    logic [LANES-1:0]            lane_ovf;

    // ACC-mode state
    logic signed [ACC_WIDTH-1:0] acc_q [LANES];
    logic [LANES-1:0]            acc_ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] a_l;
        logic signed [DATA_WIDTH-1:0] b_l;
        logic signed [DATA_WIDTH:0]   ab_sum;
        logic signed [ACC_WIDTH-1:0]  ewa_ext;
        logic signed [ACC_WIDTH-1:0]  op_a;
        logic signed [ACC_WIDTH-1:0]  op_b;
        logic signed [ACC_WIDTH:0]    sum;

        assign a_l       = a_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_l       = b_in[g*DATA_WIDTH +: DATA_WIDTH];
        assign prod_d[g] = PW'(a_l) * PW'(b_l);
        assign ab_sum    = (DATA_WIDTH+1)'(a_l) + (DATA_WIDTH+1)'(b_l);
        assign ewa_ext   = ACC_WIDTH'(ab_sum);
        assign ewa_d[g]  = ewa_ext <<< FRAC_BITS;

        // EWA takes the pre-shifted sum. Every other mode takes the sign-extended product.
        assign op_a = (s1_mode == MODE_EWA) ? s1_ewa[g] : ACC_WIDTH'(s1_prod[g]);

        // Select the second addend: partial sum, internal accumulator or zero.
        always_comb begin
            op_b = '0;
            case (s1_mode)
                MODE_MAC: op_b = s1_acc[g];
                MODE_ACC: op_b = acc_q[g];
                default:  op_b = '0;
            endcase
        end

        assign sum          = (ACC_WIDTH+1)'(op_a) + (ACC_WIDTH+1)'(op_b);
        assign lane_ovf[g]  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        assign lane_res[g]  = (lane_ovf[g] && s1_sat) ? (sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX)
                                                      : sum[ACC_WIDTH-1:0];
    end

    // Stage 1: capture the products, EWA terms and beat controls on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_MAC;
            s1_last  <= 1'b0;
            s1_sat   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
                s1_ewa[i]  <= '0;
                s1_acc[i]  <= '0;
            end
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_t'(mode);
                s1_last <= in_last;
                s1_sat  <= sat_en;
                for (int i = 0; i < LANES; i++) begin
                    s1_prod[i] <= prod_d[i];
                    s1_ewa[i]  <= ewa_d[i];
                    s1_acc[i]  <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    // Stage 2: register the output beat, or fold a non-final ACC beat into the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            result_out <= '0;
            out_ovf    <= '0;
            acc_cnt    <= '0;
            acc_ovf    <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else if (advance) begin
            if (s1_valid && s1_mode == MODE_ACC && !s1_last) begin
                out_valid <= 1'b0;
                acc_ovf   <= acc_ovf | lane_ovf;
                if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
                for (int i = 0; i < LANES; i++) acc_q[i] <= lane_res[i];
            end else if (s1_valid) begin
                out_valid <= 1'b1;
                for (int i = 0; i < LANES; i++) result_out[i*ACC_WIDTH +: ACC_WIDTH] <= lane_res[i];
                if (s1_mode == MODE_ACC) begin
                    // The final beat reports overflow from anywhere in the sequence, then closes it.
                    out_ovf <= lane_ovf | acc_ovf;
                    acc_ovf <= '0;
                    acc_cnt <= '0;
                    for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                end else begin
                    out_ovf <= lane_ovf;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_vec_pipe.sv
// Bench for pe_vec_pipe. It uses a vector table, hand-written ACC, stall and
// reset sequences, and a randomized stream. A lane-arithmetic reference model
// predicts every output beat into an expected queue.
module tb_pe_vec_pipe;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int FB    = 8;
    localparam int CW    = 8;
    localparam int W     = LANES*AW + LANES;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          mode;
    logic                in_last;
    logic                sat_en;
    logic [LANES*DW-1:0] a_in;
    logic [LANES*DW-1:0] b_in;
    logic [LANES*AW-1:0] acc_in;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*AW-1:0] result_out;
    logic [LANES-1:0]    out_ovf;
    logic [CW-1:0]       acc_cnt;

    pe_vec_pipe #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_last(in_last), .sat_en(sat_en), .a_in(a_in), .b_in(b_in), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .out_ovf(out_ovf), .acc_cnt(acc_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard state
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     last_out;
    int               n_out = 0;
    logic             held = 1'b0;
    logic [W-1:0]     held_val;
    logic             bp_random = 1'b0;

    // reference model state
    longint           m_acc [LANES];
    logic [LANES-1:0] m_ovf;
    int               m_cnt;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) m_acc[i] = 0;
        m_ovf = '0;
        m_cnt = 0;
    endtask

    // Lane arithmetic on 64-bit integers. Overflow means the result falls outside the AW-bit signed range.
    task automatic model_beat(input logic [1:0] md, input logic lst, input logic sat,
                              input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                              input logic [LANES*AW-1:0] acc);
        logic [LANES*AW-1:0] r;
        logic [LANES-1:0]    ov;
        longint              av, bv, opa, opb, s;
        logic [63:0]         su;
        for (int i = 0; i < LANES; i++) begin
            av = longint'($signed(a[i*DW +: DW]));
            bv = longint'($signed(b[i*DW +: DW]));
            if (md == 2'd2) opa = (av + bv) * longint'(1 << FB);
            else            opa = av * bv;
            case (md)
                2'd0:    opb = longint'($signed(acc[i*AW +: AW]));
                2'd3:    opb = m_acc[i];
                default: opb = 0;
            endcase
            s = opa + opb;
            ov[i] = (s > MAXV) || (s < MINV);
            if (ov[i] && sat) s = (s > 0) ? MAXV : MINV;
            su = s;
            r[i*AW +: AW] = su[AW-1:0];
            if (md == 2'd3 && !lst) m_acc[i] = longint'($signed(su[AW-1:0]));
        end
        if (md == 2'd3 && !lst) begin
            m_ovf = m_ovf | ov;
            m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
        end else begin
            if (md == 2'd3) begin
                ov = ov | m_ovf;
                model_reset();
            end
            exp_q.push_back({ov, r});
        end
    endtask

    // output monitor: compare each handshaked beat and check stability during stalls
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) check("hold_stable", {out_valid, out_ovf, result_out}, {1'b1, held_val});
            held     = out_valid && !out_ready;
            held_val = {out_ovf, result_out};
            if (out_valid && out_ready) begin
                n_out++;
                last_out = {out_ovf, result_out};
                if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
                else                   check("result", {out_ovf, result_out}, exp_q.pop_front());
            end
        end
    end

    // random backpressure
    always @(posedge clk) begin
        if (bp_random) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver: present a beat and hold it until accepted (bounded)
    task automatic send(input logic [1:0] md, input logic lst, input logic sat,
                        input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                        input logic [LANES*AW-1:0] acc);
        logic accepted;
        accepted = 1'b0;
        mode = md; in_last = lst; sat_en = sat; a_in = a; b_in = b; acc_in = acc;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        if (accepted) model_beat(md, lst, sat, a, b, acc);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) step(1);
        check("drain", exp_q.size(), 0);
        step(3);
    endtask

    function automatic logic [DW-1:0] rand16();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [AW-1:0] rand32();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]    md;
        logic          lst;
        logic          sat;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] acc;
        logic [AW-1:0] res;
        logic          ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [LANES*DW-1:0] ra, rb;
        logic [LANES*AW-1:0] rc;

        tbl[0] = '{2'd0, 1'b0, 1'b1, 16'h0100, 16'h0200, 32'h00010000, 32'h00030000, 1'b0};
        tbl[1] = '{2'd2, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 32'h0,        32'h00FFFE00, 1'b0};
        tbl[2] = '{2'd2, 1'b0, 1'b1, 16'h8000, 16'h8000, 32'h0,        32'hFF000000, 1'b0};
        tbl[3] = '{2'd0, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
        tbl[4] = '{2'd0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF, 32'hBFFF0000, 1'b1};
        tbl[5] = '{2'd1, 1'b0, 1'b1, 16'h8000, 16'h8000, 32'h12345678, 32'h40000000, 1'b0};
        tbl[6] = '{2'd0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 32'h80000000, 32'h80000000, 1'b1};
        tbl[7] = '{2'd0, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 32'h80000000, 32'h40008000, 1'b1};
        tbl[8] = '{2'd1, 1'b0, 1'b0, 16'h0100, 16'hFF00, 32'h0,        32'hFFFF0000, 1'b0};
        tbl[9] = '{2'd3, 1'b1, 1'b1, 16'h0100, 16'h0100, 32'h0,        32'h00010000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; in_last = 1'b0; sat_en = 1'b0;
        a_in = '0; b_in = '0; acc_in = '0; out_ready = 1'b1;
        model_reset();
        step(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result_out, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_acc_cnt", acc_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        step(2);

        // latency: accept to out_valid is two cycles
        send(2'd0, 1'b0, 1'b1, {4{16'h0100}}, {4{16'h0200}}, {4{32'h00010000}});
        check("latency_c1", out_valid, 0);
        step(1);
        check("latency_c2", out_valid, 1);
        drain();

        // table vectors
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].md, tbl[i].lst, tbl[i].sat, {4{tbl[i].a}}, {4{tbl[i].b}}, {4{tbl[i].acc}});
            drain();
            check($sformatf("vec%0d", i), last_out, {{4{tbl[i].ovf}}, {4{tbl[i].res}}});
        end

        // three-beat ACC sequence
        n0 = n_out;
        send(2'd3, 1'b0, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("acc_cnt_1", acc_cnt, 1);
        send(2'd3, 1'b0, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("acc_cnt_2", acc_cnt, 2);
        send(2'd3, 1'b1, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("acc_cnt_0", acc_cnt, 0);
        check("acc_seq_result", last_out, {4'h0, {4{32'h00030000}}});
        check("acc_seq_beats", n_out - n0, 1);

        // sticky ACC overflow, with a MAC beat interleaved into the open sequence
        for (int i = 0; i < 3; i++) send(2'd3, 1'b0, 1'b1, {4{16'h7FFF}}, {4{16'h7FFF}}, '0);
        send(2'd3, 1'b0, 1'b1, '0, '0, '0);
        send(2'd0, 1'b1, 1'b1, {4{16'h0001}}, {4{16'h0001}}, {4{32'h5}});
        drain();
        check("interleave_mac", last_out, {4'h0, {4{32'h6}}});
        check("interleave_cnt", acc_cnt, 4);
        send(2'd3, 1'b1, 1'b1, '0, '0, '0);
        drain();
        check("sticky_ovf", last_out, {4'hF, {4{32'h7FFFFFFF}}});
        send(2'd3, 1'b1, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("sticky_cleared", last_out, {4'h0, {4{32'h00010000}}});

        // 16-beat stream with a 5-cycle stall in the middle
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(2'd0, 1'b0, 1'($urandom_range(0, 1)), {rand16(), rand16(), rand16(), rand16()},
                         {rand16(), rand16(), rand16(), rand16()}, {rand32(), rand32(), rand32(), rand32()});
            end
            begin
                step(6);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out - n0, 16);

        // randomized stream with random backpressure
        bp_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            for (int l = 0; l < LANES; l++) begin
                ra[l*DW +: DW] = rand16();
                rb[l*DW +: DW] = rand16();
                rc[l*AW +: AW] = rand32();
            end
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ra, rb, rc);
        end
        bp_random = 1'b0;
        step(1);
        out_ready = 1'b1;
        drain();
        check("random_acc_cnt", acc_cnt, m_cnt);

        // close any open sequence, then reset in the middle of a new one
        send(2'd3, 1'b1, 1'b0, '0, '0, '0);
        drain();
        send(2'd3, 1'b0, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        send(2'd3, 1'b0, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("pre_rst_cnt", acc_cnt, 2);
        rst = 1'b1;
        #2;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result_out, 0);
        check("mid_rst_ovf", out_ovf, 0);
        check("mid_rst_acc_cnt", acc_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        model_reset();
        exp_q.delete();
        step(2);
        rst = 1'b0;
        step(1);
        send(2'd3, 1'b1, 1'b1, {4{16'h0100}}, {4{16'h0100}}, '0);
        drain();
        check("post_rst_acc", last_out, {4'h0, {4{32'h00010000}}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
